// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    typedef logic [1:0] slot_t;

    // Entry [n] is the pattern for digit n; the concatenation lists 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam seg_t SEG_DASH  = 7'h3f;
    localparam seg_t SEG_BLANK = 7'h7f;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not decimal digits and show a dash.
module bcd7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/seg_scan4.sv
// Time-multiplexed driver for a 4-digit MM:SS seven-segment display.
// Digits are latched once per full scan so a refresh never mixes old and new time.
module seg_scan4
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]                div_q;
    slot_t                           idx_q;
    logic [NUM_DIGITS-1:0][3:0]      shadow_q;
    logic [NUM_DIGITS-1:0]           shadow_dp_q;

    logic  tick;
    logic  capture;
    logic  blank;
    bcd_t  cur_digit;
    seg_t  dec_seg;

    assign tick      = (div_q == DIV_LAST);
    assign capture   = tick && (idx_q == 2'd3);
    assign cur_digit = shadow_q[idx_q];
    // Blank a leading zero in the minute-tens position only; the enable stays on.
    assign blank     = BLANK_LZ && (idx_q == 2'd3) && (shadow_q[3] == 4'd0);

    bcd7seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
            if (capture) begin
                shadow_q    <= {d3, d2, d1, d0};
                shadow_dp_q <= dp_mask;
            end
            an  <= ~(4'b0001 << idx_q);
            seg <= blank ? SEG_BLANK : dec_seg;
            dp  <= ~shadow_dp_q[idx_q];
        end
    end

endmodule
